// File: rtl/apbocp_mcfifo.sv
// Multi-channel FIFO bridge: an OCP slave pushes words into per-channel FIFOs,
// an APB slave pops them and reads/clears per-channel status.
module apbocp_mcfifo #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NCHAN         = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int STALL_ON_FULL = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [ADDR_WIDTH-1:0]   apb_paddr,
  input  logic                    apb_psel,
  input  logic                    apb_penable,
  input  logic                    apb_pwrite,
  input  logic [DATA_WIDTH-1:0]   apb_pwdata,
  output logic [DATA_WIDTH-1:0]   apb_prdata,
  output logic                    apb_pready,
  input  logic [ADDR_WIDTH-1:0]   ocp_maddr,
  input  logic [2:0]              ocp_mcmd,
  input  logic [DATA_WIDTH-1:0]   ocp_mdata,
  input  logic [DATA_WIDTH/8-1:0] ocp_mbyteen,
  output logic                    ocp_scmdaccept,
  output logic [DATA_WIDTH-1:0]   ocp_sdata,
  output logic [1:0]              ocp_sresp,
  output logic [NCHAN-1:0]        irq
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CHB = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [CHB:0] NCHAN_L = (CHB+1)'(NCHAN);
  localparam logic         STALL_L = (STALL_ON_FULL != 0);
  localparam logic [2:0]   CMD_WR    = 3'd1;
  localparam logic [2:0]   CMD_RD    = 3'd2;
  localparam logic [1:0]   RESP_NULL = 2'd0;
  localparam logic [1:0]   RESP_DVA  = 2'd1;
  localparam logic [1:0]   RESP_ERR  = 2'd3;

  function automatic logic [DATA_WIDTH-1:0] status_word(
    input logic empty, input logic full, input logic ovf, input logic unf,
    input logic [CW-1:0] cnt);
    logic [DATA_WIDTH-1:0] w;
    w          = '0;
    w[0]       = empty;
    w[1]       = full;
    w[2]       = ovf;
    w[3]       = unf;
    w[16 +: CW] = cnt;
    return w;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [NCHAN][FIFO_DEPTH];
  logic [CW-1:0]         wr_ptr_r [NCHAN];
  logic [CW-1:0]         rd_ptr_r [NCHAN];
  logic [NCHAN-1:0]      ovf_r, unf_r;
  logic [1:0]            sresp_r;
  logic [DATA_WIDTH-1:0] sdata_r;

  logic [NCHAN-1:0]      empty_s, full_s, push_s, pop_s;
  logic [NCHAN-1:0]      ovf_set_s, unf_set_s, ovf_clr_s, unf_clr_s;
  logic [NCHAN-1:0]      ocp_sel_s, apb_sel_s;
  logic [DATA_WIDTH-1:0] status_s [NCHAN];
  logic [DATA_WIDTH-1:0] ocp_status_sel_s, apb_rdata_s, sdata_nxt_s;
  logic [1:0]            sresp_nxt_s;
  logic                  ocp_full_sel_s, accept_s;

  wire [CHB-1:0] ocp_ch_s      = ocp_maddr[CHB+1:2];
  wire           ocp_ch_ok_s   = ({1'b0, ocp_ch_s} < NCHAN_L);
  wire           ocp_wr_s      = (ocp_mcmd == CMD_WR);
  wire           ocp_rd_s      = (ocp_mcmd == CMD_RD);
  wire [CHB-1:0] apb_ch_s      = apb_paddr[CHB+2:3];
  wire           apb_ch_ok_s   = ({1'b0, apb_ch_s} < NCHAN_L);
  wire           apb_access_s  = apb_psel & apb_penable;
  wire           apb_status_s  = apb_paddr[2];
  wire           unused_ok_s   = ^{ocp_mbyteen, ocp_maddr, apb_paddr, apb_pwdata};

  // Per-channel occupancy, status word and channel decode for both buses
  always_comb begin
    ocp_full_sel_s   = 1'b0;
    ocp_status_sel_s = '0;
    apb_rdata_s      = '0;
    for (int i = 0; i < NCHAN; i++) begin
      empty_s[i]   = (wr_ptr_r[i] == rd_ptr_r[i]);
      full_s[i]    = (wr_ptr_r[i][AW-1:0] == rd_ptr_r[i][AW-1:0]) &&
                     (wr_ptr_r[i][AW] != rd_ptr_r[i][AW]);
      status_s[i]  = status_word(empty_s[i], full_s[i], ovf_r[i], unf_r[i],
                                 wr_ptr_r[i] - rd_ptr_r[i]);
      ocp_sel_s[i] = ocp_ch_ok_s && (ocp_ch_s == CHB'(i));
      apb_sel_s[i] = apb_ch_ok_s && (apb_ch_s == CHB'(i));

      // Full only blocks the push; with STALL the command is never accepted
      push_s[i]    = ocp_wr_s & ocp_sel_s[i] & ~full_s[i];
      ovf_set_s[i] = ocp_wr_s & ocp_sel_s[i] & full_s[i] & ~STALL_L;

      pop_s[i]     = apb_access_s & ~apb_pwrite & ~apb_status_s & apb_sel_s[i] & ~empty_s[i];
      unf_set_s[i] = apb_access_s & ~apb_pwrite & ~apb_status_s & apb_sel_s[i] & empty_s[i];
      ovf_clr_s[i] = apb_access_s & apb_pwrite & apb_status_s & apb_sel_s[i] & apb_pwdata[2];
      unf_clr_s[i] = apb_access_s & apb_pwrite & apb_status_s & apb_sel_s[i] & apb_pwdata[3];

      ocp_full_sel_s   = ocp_full_sel_s | (ocp_sel_s[i] & full_s[i]);
      ocp_status_sel_s = ocp_status_sel_s | ({DATA_WIDTH{ocp_sel_s[i]}} & status_s[i]);
      apb_rdata_s      = apb_rdata_s
                       | ({DATA_WIDTH{pop_s[i]}} & mem_r[i][rd_ptr_r[i][AW-1:0]])
                       | ({DATA_WIDTH{apb_access_s & ~apb_pwrite & apb_status_s & apb_sel_s[i]}}
                          & status_s[i]);
    end
  end

  assign accept_s       = (ocp_wr_s | ocp_rd_s) & ~(ocp_wr_s & STALL_L & ocp_full_sel_s);
  assign ocp_scmdaccept = accept_s;
  assign apb_pready     = apb_access_s;
  assign apb_prdata     = apb_rdata_s;
  assign irq            = ~empty_s;
  assign ocp_sresp      = sresp_r;
  assign ocp_sdata      = sdata_r;

  // Next OCP response, one cycle per accepted command
  always_comb begin
    sresp_nxt_s = RESP_NULL;
    sdata_nxt_s = '0;
    if (!accept_s) begin
      sresp_nxt_s = RESP_NULL;
    end else if (!ocp_ch_ok_s) begin
      sresp_nxt_s = RESP_ERR;
    end else if (ocp_wr_s) begin
      sresp_nxt_s = ocp_full_sel_s ? RESP_ERR : RESP_DVA;
    end else begin
      sresp_nxt_s = RESP_DVA;
      sdata_nxt_s = ocp_status_sel_s;
    end
  end

  // Pointers, sticky flags and response registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NCHAN; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
      end
      ovf_r   <= '0;
      unf_r   <= '0;
      sresp_r <= RESP_NULL;
      sdata_r <= '0;
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        wr_ptr_r[i] <= wr_ptr_r[i] + CW'(push_s[i]);
        rd_ptr_r[i] <= rd_ptr_r[i] + CW'(pop_s[i]);
      end
      // Set wins over a simultaneous clear
      ovf_r   <= ovf_set_s | (ovf_r & ~ovf_clr_s);
      unf_r   <= unf_set_s | (unf_r & ~unf_clr_s);
      sresp_r <= sresp_nxt_s;
      sdata_r <= sdata_nxt_s;
    end
  end

  // FIFO storage, deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i][AW-1:0]] <= ocp_mdata;
      end
    end
  end

endmodule
